// File: rtl/imem_loader.sv
// Boot loader: takes a framed byte stream (16-bit word count, LE data words, XOR checksum),
// writes the words into instruction memory and keeps the CPU in reset until the image verifies.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [23:0]       asm_q, asm_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        last_word;
  logic [15:0] hdr_count;

  assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept     = byte_valid && byte_ready;
  assign hdr_count  = {byte_in, count_q[7:0]};
  // word_idx stops at the final word instead of counting past it
  assign last_word  = (16'(word_idx_q) == (count_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    chk_d       = chk_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR0;
      end
      S_HDR0: begin
        if (accept) begin
          count_d[7:0] = byte_in;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d    = hdr_count;
          word_idx_d = '0;
          byte_idx_d = 2'd0;
          chk_d      = 8'h00;
          if ((hdr_count == 16'd0) || (hdr_count > 16'(DEPTH_WORDS))) state_d = S_ERR;
          else                                                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = byte_in;
            2'd1: asm_d[15:8]  = byte_in;
            2'd2: asm_d[23:16] = byte_in;
            default: begin
              // The write is registered, so the assembly lanes are free for the next word
              mem_we_d    = 1'b1;
              mem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
              mem_wdata_d = {byte_in, asm_q};
              if (last_word) state_d = S_CSUM;
              else           word_idx_d = word_idx_q + 1'b1;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) state_d = (byte_in == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      word_idx_q  <= '0;
      byte_idx_q  <= 2'd0;
      chk_q       <= 8'h00;
      asm_q       <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      chk_q       <= chk_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives frames byte by byte and checks every write,
// its one-cycle latency after the 4th byte, and the final done/error/cpu_hold status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          gaps = 0;
  logic [31:0] words [64];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          acc4_q    [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc4_q.delete();
  endtask

  // Present one byte and wait (bounded) until it is consumed; returns the acceptance cycle.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    acc_cyc    = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Sends header, data from words[], and either the given checksum or the XOR of the data.
  // start_at >= 0 holds start high while data byte number start_at is being sent.
  task automatic send_frame(input int n, input logic [7:0] csum, input bit use_model, input int start_at);
    int          c;
    logic [7:0]  chk;
    logic [15:0] cnt;
    logic [31:0] w;
    cnt = 16'(n);
    chk = 8'h00;
    send_byte(cnt[7:0], c);
    send_byte(cnt[15:8], c);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        if (i * 4 + j == start_at) start = 1'b1;
        send_byte(w[8*j +: 8], c);
        start = 1'b0;
        chk = chk ^ w[8*j +: 8];
        if (j == 3) acc4_q.push_back(c);
      end
    end
    send_byte(use_model ? chk : csum, c);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if ({done, error, cpu_hold} !== 3'b001) begin errors++; $display("FAIL reset_status: done/error/hold=%b want 001", {done, error, cpu_hold}); end
    // start together with reset: reset wins
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_beats_start: byte_ready=%b want 0", byte_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load3();
    words[0] = 32'h00500093; words[1] = 32'h00100113; words[2] = 32'h002081B3;
    clear_log();
    start_pulse();
    send_frame(3, 8'hD3, 1'b0, -1);
    checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL load3_write_count: got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL load3_addr[%0d]: got %h want %h", i, wr_addr_q[i], i * 4); end
      checks++; if (wr_data_q[i] !== words[i]) begin errors++; $display("FAIL load3_data[%0d]: got %h want %h", i, wr_data_q[i], words[i]); end
      checks++; if (wr_cyc_q[i] != acc4_q[i] + 1) begin errors++; $display("FAIL load3_latency[%0d]: write cycle %0d want %0d", i, wr_cyc_q[i], acc4_q[i] + 1); end
    end
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL load3_status: done/error/hold=%b want 100", {done, error, cpu_hold}); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL load3_ready_done: got %b want 0", byte_ready); end
    checks++; if (mem_addr !== 32'h8 || mem_wdata !== 32'h002081B3) begin errors++; $display("FAIL load3_hold_outputs: addr=%h data=%h want 8/002081b3", mem_addr, mem_wdata); end
  endtask

  task automatic test_bad_csum();
    clear_log();
    start_pulse();
    send_frame(3, 8'h00, 1'b0, -1);
    checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL badcsum_write_count: got %0d want 3", wr_addr_q.size()); end
    checks++; if ({done, error, cpu_hold} !== 3'b011) begin errors++; $display("FAIL badcsum_status: done/error/hold=%b want 011", {done, error, cpu_hold}); end
  endtask

  task automatic test_bad_len();
    int c;
    logic [15:0] bad [2];
    bad[0] = 16'h0000; bad[1] = 16'h0041;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      start_pulse();
      send_byte(bad[k][7:0], c);
      send_byte(bad[k][15:8], c);
      byte_valid = 1'b0;
      checks++; if ({done, error, cpu_hold} !== 3'b011) begin errors++; $display("FAIL badlen_%h_status: done/error/hold=%b want 011", bad[k], {done, error, cpu_hold}); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL badlen_%h_ready: got %b want 0", bad[k], byte_ready); end
      repeat (2) @(posedge clk); #1;
      checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL badlen_%h_writes: got %0d want 0", bad[k], wr_addr_q.size()); end
    end
  endtask

  task automatic test_full64();
    for (int i = 0; i < 64; i++)
      words[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
    clear_log();
    gaps = 1'b1;
    start_pulse();
    send_frame(64, 8'h00, 1'b1, -1);
    gaps = 1'b0;
    checks++; if (wr_addr_q.size() != 64) begin errors++; $display("FAIL full64_write_count: got %0d want 64", wr_addr_q.size()); end
    for (int i = 0; i < 64 && i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== words[i] || wr_cyc_q[i] != acc4_q[i] + 1) begin
        errors++;
        $display("FAIL full64_write[%0d]: addr=%h data=%h cyc=%0d want %h/%h/%0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i * 4, words[i], acc4_q[i] + 1);
      end
      checks++;
    end
    checks++; if (wr_addr_q.size() == 64 && wr_addr_q[63] !== 32'hFC) begin errors++; $display("FAIL full64_last_addr: got %h want fc", wr_addr_q[63]); end
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL full64_status: done/error/hold=%b want 100", {done, error, cpu_hold}); end
  endtask

  task automatic test_reset_mid();
    int c;
    words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
    clear_log();
    start_pulse();
    send_byte(8'h03, c);
    send_byte(8'h00, c);
    for (int j = 0; j < 6; j++) send_byte(8'(words[j / 4] >> (8 * (j % 4))), c);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL rstmid_write_count: got %0d want 1", wr_addr_q.size()); end
    checks++; if (wr_addr_q.size() > 0 && (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h11223344)) begin errors++; $display("FAIL rstmid_write0: addr=%h data=%h want 0/11223344", wr_addr_q[0], wr_data_q[0]); end
    checks++; if ({byte_ready, cpu_hold, done, error} !== 4'b0100) begin errors++; $display("FAIL rstmid_idle: ready/hold/done/error=%b want 0100", {byte_ready, cpu_hold, done, error}); end
    clear_log();
    start_pulse();
    send_frame(3, 8'h00, 1'b1, -1);
    checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL rstmid_reload_count: got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== words[i]) begin errors++; $display("FAIL rstmid_reload[%0d]: addr=%h data=%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], i * 4, words[i]); end
    end
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL rstmid_reload_status: done/error/hold=%b want 100", {done, error, cpu_hold}); end
  endtask

  task automatic test_back_to_back();
    // from DONE: start restarts, then a load with start pulsed mid-DATA must complete
    start_pulse();
    checks++; if ({done, cpu_hold, byte_ready} !== 3'b011) begin errors++; $display("FAIL b2b_restart: done/hold/ready=%b want 011", {done, cpu_hold, byte_ready}); end
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
    clear_log();
    send_frame(2, 8'h00, 1'b1, 5);
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL b2b_write_count: got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== words[i]) begin errors++; $display("FAIL b2b_write[%0d]: addr=%h data=%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], i * 4, words[i]); end
    end
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL b2b_status: done/error/hold=%b want 100", {done, error, cpu_hold}); end
  endtask

  initial begin
    test_reset();
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
    test_load3();
    $display("test_load3: checks=%0d errors=%0d", checks, errors);
    test_bad_csum();
    $display("test_bad_csum: checks=%0d errors=%0d", checks, errors);
    test_bad_len();
    $display("test_bad_len: checks=%0d errors=%0d", checks, errors);
    test_full64();
    $display("test_full64: checks=%0d errors=%0d", checks, errors);
    test_reset_mid();
    $display("test_reset_mid: checks=%0d errors=%0d", checks, errors);
    test_back_to_back();
    $display("test_back_to_back: checks=%0d errors=%0d", checks, errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
